// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch inject buffer.
//   OPW          : opcode field width (top bits of a fetch word)
//   state_e      : sequencer state (IDLE / SEQ)
//   seq_e        : which injection sequence is running
//   *_OP         : micro-op opcodes emitted by the sequencer
//   seq_len()    : number of micro-ops in a sequence
package fetch_pkg;

  localparam int OPW = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEQ  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SEQ_CALL = 2'd0,
    SEQ_RET  = 2'd1,
    SEQ_RTI  = 2'd2,
    SEQ_INT  = 2'd3
  } seq_e;

  localparam logic [OPW-1:0] NOP_OP     = 16'h0000;
  localparam logic [OPW-1:0] PUSH_PC_H  = 16'hB000;
  localparam logic [OPW-1:0] PUSH_PC_L  = 16'hB400;
  localparam logic [OPW-1:0] POP_PC_H   = 16'hBC00;
  localparam logic [OPW-1:0] POP_PC_L   = 16'hB800;
  localparam logic [OPW-1:0] PUSH_FLAGS = 16'h7C00;
  localparam logic [OPW-1:0] POP_FLAGS  = 16'h7800;

  // CALL/RET move only the PC; RTI/INT also move the flags word.
  function automatic logic [1:0] seq_len(input seq_e s);
    logic [1:0] len;
    len = 2'd2;
    if ((s == SEQ_RTI) || (s == SEQ_INT)) len = 2'd3;
    return len;
  endfunction

endpackage

// File: rtl/inject_rom.sv
// Combinational micro-op table.
//   seq_i    : sequence type
//   idx_i    : step within the sequence (0-based)
//   opcode_o : opcode for that step; NOP for steps past the sequence end
module inject_rom
  import fetch_pkg::*;
(
  input  seq_e           seq_i,
  input  logic [1:0]     idx_i,
  output logic [OPW-1:0] opcode_o
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    opcode_o = NOP_OP;
    case (seq_i)
      SEQ_CALL: begin
        case (idx_i)
          2'd0:    opcode_o = PUSH_PC_H;
          2'd1:    opcode_o = PUSH_PC_L;
          default: opcode_o = NOP_OP;
        endcase
      end
      SEQ_RET: begin
        case (idx_i)
          2'd0:    opcode_o = POP_PC_H;
          2'd1:    opcode_o = POP_PC_L;
          default: opcode_o = NOP_OP;
        endcase
      end
      SEQ_RTI: begin
        case (idx_i)
          2'd0:    opcode_o = POP_PC_H;
          2'd1:    opcode_o = POP_PC_L;
          2'd2:    opcode_o = POP_FLAGS;
          default: opcode_o = NOP_OP;
        endcase
      end
      SEQ_INT: begin
        case (idx_i)
          2'd0:    opcode_o = PUSH_PC_H;
          2'd1:    opcode_o = PUSH_PC_L;
          2'd2:    opcode_o = PUSH_FLAGS;
          default: opcode_o = NOP_OP;
        endcase
      end
      default: opcode_o = NOP_OP;
    endcase
  end

endmodule

// File: rtl/fetch_inject_buffer.sv
// Registered fetch->decode stage that can replace the fetched stream with
// short micro-op sequences for CALL / RET / RTI / INT.
//   clk          : clock, rising edge
//   rst          : asynchronous active-low reset
//   in_valid     : in_data holds a fetched word
//   in_data      : fetched word {opcode, operand}
//   stall        : hold every register
//   flush        : drop stage contents and abort any sequence
//   req_*        : start an injection sequence (sampled in IDLE with in_valid)
//   out_data     : registered word to decode
//   out_valid    : out_data is meaningful
//   out_injected : out_data opcode came from the sequencer
//   busy         : sequencer active, fetch must hold its PC
module fetch_inject_buffer
  import fetch_pkg::*;
#(
  parameter int WIDTH   = 48,
  parameter int OPW     = fetch_pkg::OPW,
  parameter int SEQ_MAX = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             stall,
  input  logic             flush,
  input  logic             req_call,
  input  logic             req_ret,
  input  logic             req_rti,
  input  logic             req_int,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_injected,
  output logic             busy
);

  localparam int OPND_W = WIDTH - OPW;

  state_e              state_q, state_d;
  seq_e                seq_q, seq_d;
  logic [1:0]          idx_q, idx_d;
  logic [1:0]          len_q, len_d;
  logic [OPND_W-1:0]   operand_q, operand_d;
  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                out_injected_q, out_injected_d;

  logic                req_any;
  seq_e                req_seq;
  seq_e                rom_seq;
  logic [1:0]          rom_idx;
  logic [OPW-1:0]      rom_op;

  // Requests only count alongside a valid fetch word; int > rti > ret > call.
  assign req_any = in_valid & (req_int | req_rti | req_ret | req_call);

  always_comb begin
    req_seq = SEQ_CALL;
    if (req_int)      req_seq = SEQ_INT;
    else if (req_rti) req_seq = SEQ_RTI;
    else if (req_ret) req_seq = SEQ_RET;
  end

  // In IDLE the table is addressed by the incoming request so the first op
  // leaves on the same edge that accepts the request.
  assign rom_seq = (state_q == ST_IDLE) ? req_seq : seq_q;
  assign rom_idx = (state_q == ST_IDLE) ? 2'd0 : idx_q;

  inject_rom u_rom (
    .seq_i    (rom_seq),
    .idx_i    (rom_idx),
    .opcode_o (rom_op)
  );

  always_comb begin
    // Holding is the default, which is exactly what stall needs.
    state_d        = state_q;
    seq_d          = seq_q;
    idx_d          = idx_q;
    len_d          = len_q;
    operand_d      = operand_q;
    out_data_d     = out_data_q;
    out_valid_d    = out_valid_q;
    out_injected_d = out_injected_q;

    if (flush) begin
      state_d        = ST_IDLE;
      idx_d          = 2'd0;
      out_data_d     = {NOP_OP, {OPND_W{1'b0}}};
      out_valid_d    = 1'b0;
      out_injected_d = 1'b0;
    end else if (!stall) begin
      case (state_q)
        ST_IDLE: begin
          if (req_any) begin
            state_d        = ST_SEQ;
            seq_d          = req_seq;
            len_d          = seq_len(req_seq);
            idx_d          = 2'd1;
            operand_d      = in_data[OPND_W-1:0];
            out_data_d     = {rom_op, in_data[OPND_W-1:0]};
            out_valid_d    = 1'b1;
            out_injected_d = 1'b1;
          end else begin
            out_data_d     = in_data;
            out_valid_d    = in_valid;
            out_injected_d = 1'b0;
          end
        end
        ST_SEQ: begin
          out_data_d     = {rom_op, operand_q};
          out_valid_d    = 1'b1;
          out_injected_d = 1'b1;
          if (idx_q == (len_q - 2'd1)) begin
            state_d = ST_IDLE;
            idx_d   = 2'd0;
          end else begin
            idx_d   = idx_q + 2'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = 2'd0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      seq_q          <= SEQ_CALL;
      idx_q          <= 2'd0;
      len_q          <= 2'd0;
      operand_q      <= '0;
      out_data_q     <= '0;
      out_valid_q    <= 1'b0;
      out_injected_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      seq_q          <= seq_d;
      idx_q          <= idx_d;
      len_q          <= len_d;
      operand_q      <= operand_d;
      out_data_q     <= out_data_d;
      out_valid_q    <= out_valid_d;
      out_injected_q <= out_injected_d;
    end
  end

  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign out_injected = out_injected_q;
  assign busy         = (state_q == ST_SEQ);

endmodule

// File: tb/tb_fetch_inject_buffer.sv
// Directed bench for fetch_inject_buffer with an expected-output queue:
// each driven cycle pushes the outputs expected after the next rising edge,
// and every edge pops one entry and compares it against the DUT.
module tb_fetch_inject_buffer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [47:0] in_data;
  logic        stall;
  logic        flush;
  logic        req_call;
  logic        req_ret;
  logic        req_rti;
  logic        req_int;
  logic [47:0] out_data;
  logic        out_valid;
  logic        out_injected;
  logic        busy;

  typedef struct {
    logic [47:0] data;
    logic        valid;
    logic        inj;
    logic        busy;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  fetch_inject_buffer #(.WIDTH(48), .OPW(16), .SEQ_MAX(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .stall        (stall),
    .flush        (flush),
    .req_call     (req_call),
    .req_ret      (req_ret),
    .req_rti      (req_rti),
    .req_int      (req_int),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_injected (out_injected),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, tests run %0d", tests_run);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    check({tag, ".data"},  out_data,            e.data);
    check({tag, ".valid"}, {47'd0, out_valid},    {47'd0, e.valid});
    check({tag, ".inj"},   {47'd0, out_injected}, {47'd0, e.inj});
    check({tag, ".busy"},  {47'd0, busy},         {47'd0, e.busy});
  endtask

  task automatic expect_out(input logic [47:0] d, input logic v, input logic i, input logic b);
    exp_t e;
    e.data  = d;
    e.valid = v;
    e.inj   = i;
    e.busy  = b;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic v, input logic [47:0] d,
                       input logic c, input logic r, input logic ti, input logic it);
    in_valid = v;
    in_data  = d;
    req_call = c;
    req_ret  = r;
    req_rti  = ti;
    req_int  = it;
  endtask

  // Advance one edge and compare against the oldest queued expectation.
  task automatic step(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $error("FAIL %s: scoreboard empty, observed %h expected an entry", tag, out_data);
    end else begin
      e = exp_q.pop_front();
      check_outputs(tag, e);
    end
  endtask

  initial begin
    exp_t zero_e;
    zero_e.data  = 48'h0;
    zero_e.valid = 1'b0;
    zero_e.inj   = 1'b0;
    zero_e.busy  = 1'b0;

    rst   = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    drive(1'b0, 48'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #12;
    check_outputs("reset", zero_e);
    rst = 1'b1;

    // Pass-through.
    drive(1'b1, 48'h1234_0000_00AB, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out(48'h1234_0000_00AB, 1'b1, 1'b0, 1'b0);
    step("pass0");

    // CALL: two ops, busy for exactly one cycle, SEQ ignores in_data.
    drive(1'b1, 48'hFFFF_0000_0100, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out(48'hB000_0000_0100, 1'b1, 1'b1, 1'b1);
    step("call0");
    drive(1'b1, 48'hAAAA_5555_5555, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out(48'hB400_0000_0100, 1'b1, 1'b1, 1'b0);
    step("call1");
    expect_out(48'hAAAA_5555_5555, 1'b1, 1'b0, 1'b0);
    step("call_after");

    // Request without in_valid is ignored.
    drive(1'b0, 48'h0F0F_0000_1234, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_out(48'h0F0F_0000_1234, 1'b0, 1'b0, 1'b0);
    step("req_novalid");

    // RTI with a stall on the second cycle; a request during SEQ is ignored.
    drive(1'b1, 48'h1111_DEAD_BEEF, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_out(48'hBC00_DEAD_BEEF, 1'b1, 1'b1, 1'b1);
    step("rti0");
    drive(1'b1, 48'h2222_0000_0000, 1'b0, 1'b0, 1'b0, 1'b1);
    stall = 1'b1;
    expect_out(48'hBC00_DEAD_BEEF, 1'b1, 1'b1, 1'b1);
    step("rti_stall");
    stall = 1'b0;
    expect_out(48'hB800_DEAD_BEEF, 1'b1, 1'b1, 1'b1);
    step("rti1");
    drive(1'b0, 48'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out(48'h7800_DEAD_BEEF, 1'b1, 1'b1, 1'b0);
    step("rti2");
    expect_out(48'h0, 1'b0, 1'b0, 1'b0);
    step("rti_after");

    // INT and CALL together: only INT ops appear.
    drive(1'b1, 48'h0000_0000_2000, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_out(48'hB000_0000_2000, 1'b1, 1'b1, 1'b1);
    step("int0");
    drive(1'b1, 48'h0000_0000_0042, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out(48'hB400_0000_2000, 1'b1, 1'b1, 1'b1);
    step("int1");
    expect_out(48'h7C00_0000_2000, 1'b1, 1'b1, 1'b0);
    step("int2");
    expect_out(48'h0000_0000_0042, 1'b1, 1'b0, 1'b0);
    step("int_after");

    // Flush after the first INT op, with stall also high.
    drive(1'b1, 48'h0000_0000_3000, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_out(48'hB000_0000_3000, 1'b1, 1'b1, 1'b1);
    step("fl_int0");
    flush = 1'b1;
    stall = 1'b1;
    expect_out(48'h0, 1'b0, 1'b0, 1'b0);
    step("flush");
    flush = 1'b0;
    stall = 1'b0;
    drive(1'b1, 48'h5555_0000_0077, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out(48'h5555_0000_0077, 1'b1, 1'b0, 1'b0);
    step("fl_after");

    // Stall in IDLE: request not sampled, outputs held.
    stall = 1'b1;
    drive(1'b1, 48'h6666_0000_0001, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out(48'h5555_0000_0077, 1'b1, 1'b0, 1'b0);
    step("idle_stall");
    stall = 1'b0;

    // Full RET sequence.
    drive(1'b1, 48'h7777_0000_0ABC, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_out(48'hBC00_0000_0ABC, 1'b1, 1'b1, 1'b1);
    step("ret0");
    drive(1'b0, 48'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out(48'hB800_0000_0ABC, 1'b1, 1'b1, 1'b0);
    step("ret1");

    // Reset during RET's second step: outputs clear before the next edge.
    drive(1'b1, 48'h0000_0000_CAFE, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_out(48'hBC00_0000_CAFE, 1'b1, 1'b1, 1'b1);
    step("rst_ret0");
    drive(1'b1, 48'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    #2;
    check_outputs("rst_async", zero_e);
    @(posedge clk);
    #1;
    check_outputs("rst_hold", zero_e);
    rst = 1'b1;
    drive(1'b1, 48'h9999_0000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out(48'h9999_0000_0001, 1'b1, 1'b0, 1'b0);
    step("rst_pass");
    drive(1'b0, 48'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out(48'h0, 1'b0, 1'b0, 1'b0);
    step("rst_idle");

    tests_run++;
    assert (exp_q.size() == 0) else begin
      tests_failed++;
      $error("FAIL sb_drain: observed %0d entries expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fetch_inject_buffer.md
FETCH_INJECT_BUFFER -- requirements
Module: fetch_inject_buffer

Interface
REQ-001 Parameter WIDTH, 48, total fetch word width in bits.
REQ-002 Parameter OPW, 16, opcode-field width; occupies bits [WIDTH-1:WIDTH-OPW].
REQ-003 Parameter SEQ_MAX, 3, maximum injected micro-ops per sequence.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 in_valid  in  1  in_data holds a fetched word.
REQ-007 in_data  in  WIDTH  fetched word; low WIDTH-OPW bits carry immediate/PC operand.
REQ-008 stall  in  1  hold all state and outputs.
REQ-009 flush  in  1  discard stage contents, abort any sequence.
REQ-010 req_call, req_ret, req_rti, req_int  in  1 each  start injection sequence.
REQ-011 out_data  out  WIDTH  registered word to decode.
REQ-012 out_valid  out  1  out_data is meaningful.
REQ-013 out_injected  out  1  out_data opcode came from the sequencer.
REQ-014 busy  out  1  sequencer active; fetch must not advance PC.

Function
REQ-015 Single-edge design: all registers update on rising clk only.
REQ-016 FSM states IDLE and SEQ; 2-bit step index idx and 2-bit length len.
REQ-017 Sequences, in emitted order: CALL = PUSH_PC_H, PUSH_PC_L (len 2); RET = POP_PC_H, POP_PC_L (len 2); RTI = POP_PC_H, POP_PC_L, POP_FLAGS (len 3); INT = PUSH_PC_H, PUSH_PC_L, PUSH_FLAGS (len 3).
REQ-018 Request priority in IDLE: int > rti > ret > call; lower requests in the same cycle are dropped.
REQ-019 Priority per edge: flush > stall > sequencer > pass-through.
REQ-020 flush: out_valid<=0, out_data<=0 (NOP opcode, zero operand), out_injected<=0, state<=IDLE, idx<=0, regardless of stall or requests.
REQ-021 stall (no flush): every register unchanged; requests not sampled.
REQ-022 IDLE, request present: out_data<={first op, in_data[WIDTH-OPW-1:0]}, operand latched internally, out_valid<=1, out_injected<=1, idx<=1, state<=SEQ; one-cycle latency.
REQ-023 SEQ: out_data<={op[idx], latched operand}, out_valid<=1, out_injected<=1, idx<=idx+1; after emitting op[len-1], state<=IDLE, idx<=0.
REQ-024 SEQ ignores all req_* inputs and in_data.
REQ-025 IDLE, no request: out_data<=in_data, out_valid<=in_valid, out_injected<=0.
REQ-026 busy = (state==SEQ), driven from the state register; no combinational input-to-output path.
REQ-027 Requests sampled only when in_valid=1; a request with in_valid=0 is ignored.

Reset
REQ-028 rst low asynchronously forces state=IDLE, idx=0, len=0, latched operand=0, out_data=0, out_valid=0, out_injected=0, busy=0.
REQ-029 Reset asserted mid-sequence aborts it; after release, the block resumes in IDLE with no residual injection.

Structure
REQ-030 Shared package fetch_pkg holds OPW, state enum and opcode constants: NOP_OP=16'h0000, PUSH_PC_H=16'hB000, PUSH_PC_L=16'hB400, POP_PC_H=16'hBC00, POP_PC_L=16'hB800, PUSH_FLAGS=16'h7C00, POP_FLAGS=16'h7800.
REQ-031 One sub-module, inject_rom, combinationally maps (sequence type, idx) to opcode.

Verification
REQ-032 Pass-through: in_valid=1, in_data=48'h1234_0000_00AB, no req -> next cycle out_data=48'h1234_0000_00AB, out_valid=1, out_injected=0, busy=0.
REQ-033 CALL: req_call=1, in_data low 32 bits=32'h0000_0100 -> out opcodes B000 then B400 on two consecutive cycles, operand 32'h100 both, busy high exactly one cycle.
REQ-034 RTI with stall: req_rti, then stall=1 on second cycle -> BC00, BC00 held, B800, 7800; out_injected=1 throughout; busy low after 7800.
REQ-035 Simultaneous req_int and req_call -> sequence B000, B400, 7C00 only; no CALL ops follow.
REQ-036 Flush mid-INT after first op -> next out_data=0, out_valid=0, busy=0; following pass-through word unaffected.
REQ-037 rst low during RET second step -> outputs zero immediately, before the next clk edge; after release, pass-through resumes with no injected op.
